// File: rtl/kernel_launch_pkg.sv
// Shared definitions for the kernel launch CSR block: register map, STATUS layout,
// launch FSM states and the completion popcount helper.
package kernel_launch_pkg;

    localparam logic [15:0] OFF_CTRL     = 16'd0;
    localparam logic [15:0] OFF_STATUS   = 16'd2;
    localparam logic [15:0] OFF_NUM_WG   = 16'd4;
    localparam logic [15:0] OFF_ARG_BASE = 16'd6;
    localparam logic [15:0] OFF_CYCLES   = 16'd8;

    localparam int ST_BUSY      = 0;
    localparam int ST_DONE      = 1;
    localparam int ST_ABORTED   = 2;
    localparam int ST_OUTST_LSB = 8;
    localparam int ST_COMPL_LSB = 16;

    localparam int OUTST_W = 8;

    typedef enum logic [1:0] {
        KL_IDLE     = 2'd0,
        KL_DISPATCH = 2'd1,
        KL_DRAIN    = 2'd2
    } t_kl_state;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer;
// the pointer moves past the granted requester only when advance is high.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] gnt_idx;

    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = PTR_W'((int'(ptr_q) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= PTR_W'((int'(gnt_idx) + 1) % N);
        end
    end

endmodule

// File: rtl/kernel_launch_csr.sv
// MMIO sub-CSR that configures a kernel launch and hands work-group ids round-robin
// to ready compute units, tracking outstanding/completed WGs and launch duration.
module kernel_launch_csr
    import kernel_launch_pkg::*;
#(
    parameter int          NUM_CU    = 4,
    parameter int          WG_W      = 32,
    parameter logic [15:0] BASE_ADDR = 16'h0010
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       mmio_address,
    input  logic [8:0]        mmio_tid,
    input  logic [63:0]       mmio_wr_data,
    input  logic              mmio_rd_valid,
    input  logic              mmio_wr_valid,
    output logic              mmio_rsp_valid,
    output logic [8:0]        mmio_rsp_tid,
    output logic [63:0]       mmio_rsp_data,
    output logic [NUM_CU-1:0] cu_wg_valid,
    output logic [WG_W-1:0]   cu_wg_id,
    output logic [63:0]       cu_arg_base,
    input  logic [NUM_CU-1:0] cu_wg_ready,
    input  logic [NUM_CU-1:0] cu_wg_done,
    output logic              kernel_busy
);

    t_kl_state            state_q, state_d;
    logic [WG_W-1:0]      num_wg_q, next_id_q, completed_q;
    logic [63:0]          arg_base_q, cycles_q;
    logic [OUTST_W-1:0]   outstanding_q, outst_d;
    logic                 done_q, aborted_q;

    logic wr_ctrl, start_cmd, abort_cmd, wr_num_wg, wr_arg;
    logic dispatch_ok, transfer, last_id;
    logic start_go, abort_go, drain_exit;
    logic [4:0]           done_cnt;
    logic [OUTST_W:0]     outst_sum;
    logic [NUM_CU-1:0]    arb_req;
    logic [63:0]          status_word, rd_data;

    assign wr_ctrl   = mmio_wr_valid && (mmio_address == BASE_ADDR + OFF_CTRL);
    assign start_cmd = wr_ctrl && mmio_wr_data[0];
    assign abort_cmd = wr_ctrl && mmio_wr_data[1];
    assign wr_num_wg = mmio_wr_valid && (mmio_address == BASE_ADDR + OFF_NUM_WG);
    assign wr_arg    = mmio_wr_valid && (mmio_address == BASE_ADDR + OFF_ARG_BASE);

    // An abort landing this cycle suppresses the offer so no WG slips out behind it.
    assign dispatch_ok = (state_q == KL_DISPATCH) && (outstanding_q != '1) && !abort_cmd;
    assign arb_req     = cu_wg_ready & {NUM_CU{dispatch_ok}};

    rr_arbiter #(.N(NUM_CU)) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (arb_req),
        .advance (transfer),
        .gnt     (cu_wg_valid)
    );

    assign transfer    = |cu_wg_valid;
    assign last_id     = (next_id_q == num_wg_q - WG_W'(1));
    assign done_cnt    = popcount16(16'(cu_wg_done));
    assign cu_wg_id    = next_id_q;
    assign cu_arg_base = arg_base_q;
    assign kernel_busy = (state_q != KL_IDLE);

    // Spurious completions clamp at zero rather than wrapping the in-flight count.
    always_comb begin
        outst_sum = {1'b0, outstanding_q} + (OUTST_W+1)'(transfer);
        if (outst_sum >= (OUTST_W+1)'(done_cnt)) begin
            outst_d = OUTST_W'(outst_sum - (OUTST_W+1)'(done_cnt));
        end else begin
            outst_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= KL_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        start_go   = 1'b0;
        abort_go   = 1'b0;
        drain_exit = 1'b0;
        case (state_q)
            KL_IDLE: begin
                if (start_cmd) begin
                    start_go = 1'b1;
                    if (num_wg_q != '0) state_d = KL_DISPATCH;
                end
            end
            KL_DISPATCH: begin
                if (abort_cmd) begin
                    abort_go = 1'b1;
                    state_d  = KL_DRAIN;
                end else if (transfer && last_id) begin
                    state_d = KL_DRAIN;
                end
            end
            KL_DRAIN: begin
                if (outst_d == '0) begin
                    drain_exit = 1'b1;
                    state_d    = KL_IDLE;
                end
            end
            default: state_d = KL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_wg_q      <= '0;
            arg_base_q    <= '0;
            next_id_q     <= '0;
            completed_q   <= '0;
            outstanding_q <= '0;
            cycles_q      <= '0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            if (state_q != KL_IDLE) begin
                completed_q   <= completed_q + WG_W'(done_cnt);
                outstanding_q <= outst_d;
                cycles_q      <= cycles_q + 64'd1;
            end
            if (transfer) next_id_q <= next_id_q + WG_W'(1);
            if (start_go) begin
                done_q      <= (num_wg_q == '0);
                aborted_q   <= 1'b0;
                completed_q <= '0;
                cycles_q    <= '0;
                next_id_q   <= '0;
            end
            if (abort_go)   aborted_q <= 1'b1;
            if (drain_exit) done_q    <= 1'b1;
            if (state_q == KL_IDLE && wr_num_wg) num_wg_q   <= mmio_wr_data[WG_W-1:0];
            if (state_q == KL_IDLE && wr_arg)    arg_base_q <= mmio_wr_data;
        end
    end

    always_comb begin
        status_word                            = '0;
        status_word[ST_BUSY]                   = kernel_busy;
        status_word[ST_DONE]                   = done_q;
        status_word[ST_ABORTED]                = aborted_q;
        status_word[ST_OUTST_LSB +: OUTST_W]   = outstanding_q;
        status_word[ST_COMPL_LSB +: WG_W]      = completed_q;
        rd_data = '0;
        if (mmio_address == BASE_ADDR + OFF_CTRL || mmio_address == BASE_ADDR + OFF_STATUS) begin
            rd_data = status_word;
        end else if (mmio_address == BASE_ADDR + OFF_NUM_WG) begin
            rd_data = 64'(num_wg_q);
        end else if (mmio_address == BASE_ADDR + OFF_ARG_BASE) begin
            rd_data = arg_base_q;
        end else if (mmio_address == BASE_ADDR + OFF_CYCLES) begin
            rd_data = cycles_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mmio_rsp_valid <= 1'b0;
            mmio_rsp_tid   <= '0;
            mmio_rsp_data  <= '0;
        end else begin
            mmio_rsp_valid <= mmio_rd_valid;
            if (mmio_rd_valid) begin
                mmio_rsp_tid  <= mmio_tid;
                mmio_rsp_data <= rd_data;
            end
        end
    end

endmodule
